// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample path: accumulator state encoding,
// window-depth helper and the default widths shared with the shift stage.
package adc_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

    localparam int ADC_IN_WIDTH  = 12;
    localparam int ADC_SUM_WIDTH = 16;
    localparam int ADC_SHIFT     = 4;

    function automatic int acc_depth(input int shift);
        return 1 << shift;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Ring buffer of 2^SHIFT samples. The slot at wr_ptr holds the oldest sample;
// it is read combinationally and overwritten by the next accepted sample.
module sample_ring_buffer
    import adc_pkg::*;
#(
    parameter int IN_WIDTH = ADC_IN_WIDTH,
    parameter int SHIFT    = ADC_SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [IN_WIDTH-1:0] wr_data,
    output logic [IN_WIDTH-1:0] oldest,
    output logic [SHIFT-1:0]    wr_ptr
);

    localparam int DEPTH = acc_depth(SHIFT);

    // Contents are never reset; the accumulator ignores them until the window fills.
    logic [IN_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign oldest = mem[wr_ptr];

endmodule

// File: rtl/adc_window_accumulator.sv
// Boxcar accumulator: running sum of the last 2^SHIFT ADC samples.
// Define ADC_ACCUM_DECIMATE_EN to emit only non-overlapping block sums.
//
// Handshake: a sample is taken on every clk edge with in_valid high and clear
// low; out_valid is a one-cycle pulse with no backpressure, out holds between pulses.
module adc_window_accumulator
    import adc_pkg::*;
#(
    parameter int IN_WIDTH = ADC_IN_WIDTH,
    parameter int SHIFT    = ADC_SHIFT,
    parameter int WIDTH    = ADC_SUM_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] in,
    input  logic                in_valid,
    input  logic                clear,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid,
    output logic                full
);

    localparam int DEPTH = acc_depth(SHIFT);

    generate
        if (IN_WIDTH + SHIFT > WIDTH) begin : g_width_check
            $error("adc_window_accumulator: IN_WIDTH + SHIFT must not exceed WIDTH");
        end
    endgenerate

    acc_state_t          state;
    acc_state_t          state_next;
    logic [SHIFT-1:0]    fill_cnt;
    logic [SHIFT-1:0]    fill_cnt_next;
    logic [WIDTH-1:0]    sum;
    logic [WIDTH-1:0]    sum_next;
    logic [WIDTH:0]      sum_wide;
    logic [IN_WIDTH-1:0] oldest;
    logic [IN_WIDTH-1:0] oldest_eff;
    logic [SHIFT-1:0]    wr_ptr;
    logic                accept;
    logic                emit;
    logic                result;

    assign accept = in_valid && !clear;

    sample_ring_buffer #(
        .IN_WIDTH (IN_WIDTH),
        .SHIFT    (SHIFT)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (in),
        .oldest  (oldest),
        .wr_ptr  (wr_ptr)
    );

`ifdef ADC_ACCUM_DECIMATE_EN
    // The sample written at the last slot closes a block of 2^SHIFT.
    assign emit = (wr_ptr == {SHIFT{1'b1}});
`else
    assign emit = 1'b1;
`endif

    // During FILL the ring slot is stale, so nothing leaves the window.
    assign oldest_eff = (state == FILL) ? '0 : oldest;

    // The intermediate sum + in can exceed WIDTH bits before the subtract.
    assign sum_wide = {1'b0, sum}
                    + {{(WIDTH + 1 - IN_WIDTH){1'b0}}, in}
                    - {{(WIDTH + 1 - IN_WIDTH){1'b0}}, oldest_eff};

    always_comb begin
        state_next    = state;
        fill_cnt_next = fill_cnt;
        sum_next      = sum;
        result        = 1'b0;
        if (clear) begin
            state_next    = FILL;
            fill_cnt_next = '0;
            sum_next      = '0;
        end else if (accept) begin
            sum_next = sum_wide[WIDTH-1:0];
            case (state)
                FILL: begin
                    fill_cnt_next = fill_cnt + 1'b1;
                    if (fill_cnt == {SHIFT{1'b1}}) begin
                        state_next = RUN;
                        result     = emit;
                    end
                end
                RUN: begin
                    result = emit;
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            sum       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            state     <= state_next;
            fill_cnt  <= fill_cnt_next;
            sum       <= sum_next;
            out_valid <= result;
            full      <= (state_next == RUN);
            if (clear) begin
                out <= '0;
            end else if (result) begin
                out <= sum_next;
            end
        end
    end

    // While filling, the fill counter and write pointer advance in lockstep.
    fill_tracks_ptr: assert property (
        @(posedge clk) disable iff (reset) (state == FILL) |-> (fill_cnt == wr_ptr)
    );

    logic unused_depth;
    assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_adc_window_accumulator.sv
// Self-checking bench for adc_window_accumulator: directed cases with literal
// expectations plus randomized traffic checked against a window-queue model.
module tb_adc_window_accumulator;

    localparam int IN_WIDTH = 12;
    localparam int SHIFT    = 4;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 1 << SHIFT;

`ifdef ADC_ACCUM_DECIMATE_EN
    localparam bit DECIM = 1'b1;
`else
    localparam bit DECIM = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [IN_WIDTH-1:0] in = '0;
    logic                in_valid = 1'b0;
    logic                clear = 1'b0;
    logic [WIDTH-1:0]    out;
    logic                out_valid;
    logic                full;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    adc_window_accumulator #(
        .IN_WIDTH (IN_WIDTH),
        .SHIFT    (SHIFT),
        .WIDTH    (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .full      (full)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The window is a plain queue of the samples accepted since the last flush;
    // a result is the arithmetic sum of whatever is in it.
    int unsigned     win_q[$];
    int unsigned     m_cnt = 0;
    logic [WIDTH-1:0] m_out = '0;
    bit              m_valid = 1'b0;
    bit              m_full = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    always @(posedge clk) begin
        if (reset || clear) begin
            win_q.delete();
            m_cnt   = 0;
            m_out   = '0;
            m_valid = 1'b0;
            m_full  = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (in_valid) begin
                int unsigned s;
                win_q.push_back(int'(in));
                if (win_q.size() > DEPTH) void'(win_q.pop_front());
                m_cnt++;
                if (m_cnt >= DEPTH) begin
                    m_full = 1'b1;
                    if (!DECIM || (m_cnt % DEPTH == 0)) begin
                        s = 0;
                        foreach (win_q[i]) s += win_q[i];
                        m_out   = WIDTH'(s);
                        m_valid = 1'b1;
                        exp_q.push_back(WIDTH'(s));
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out", 32'(out), 32'(m_out));
            check("full", 32'(full), 32'(m_full));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_unexpected", 32'(out), 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    check("scoreboard_sum", 32'(out), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle; outputs are observable #1 after the edge on return.
    task automatic drive(input bit v, input logic [IN_WIDTH-1:0] d, input bit c);
        @(negedge clk);
        in_valid = v;
        in       = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        logic [WIDTH-1:0] sums[3];
        logic [WIDTH-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_full", 32'(full), 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        checking = 1'b1;

        // Fill with 0x100: silent until the 16th sample.
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 12'h100, 1'b0);
            if (k < DEPTH) check("fill_no_valid", 32'(out_valid), 32'h0);
        end
        check("fill_sum", 32'(out), 32'h1000);
        check("fill_valid", 32'(out_valid), 32'h1);
        check("fill_full", 32'(full), 32'h1);
        idle(1);
        check("pulse_one_cycle", 32'(out_valid), 32'h0);
        check("out_holds", 32'(out), 32'h1000);

`ifndef ADC_ACCUM_DECIMATE_EN
        drive(1'b1, 12'h000, 1'b0);
        check("slide_first_zero", 32'(out), 32'h0F00);
        for (int k = 0; k < DEPTH; k++) drive(1'b1, 12'h000, 1'b0);
        check("slide_all_zero", 32'(out), 32'h0000);
        for (int k = 0; k < DEPTH; k++) drive(1'b1, 12'hFFF, 1'b0);
        check("max_sum", 32'(out), 32'hFFF0);
        drive(1'b1, 12'h000, 1'b0);
        check("max_minus_one", 32'(out), 32'hEFF1);

        // Gapped input: one pulse per sample, out stable in the gaps.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, IN_WIDTH'($urandom_range(0, 4095)), 1'b0);
            check("gap_valid", 32'(out_valid), 32'h1);
            held = out;
            idle(3);
            check("gap_stable", 32'(out), 32'(held));
        end
`endif

        // Clear mid-window together with a sample that must be dropped.
        for (int k = 0; k < 5; k++) drive(1'b1, IN_WIDTH'($urandom_range(0, 4095)), 1'b0);
        drive(1'b1, 12'h7FF, 1'b1);
        check("clear_out", 32'(out), 32'h0);
        check("clear_full", 32'(full), 32'h0);
        check("clear_valid", 32'(out_valid), 32'h0);
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 12'h001, 1'b0);
            if (k < DEPTH) check("refill_no_valid", 32'(out_valid), 32'h0);
        end
        check("refill_valid", 32'(out_valid), 32'h1);
        check("refill_sum", 32'(out), 32'h0010);

`ifdef ADC_ACCUM_DECIMATE_EN
        drive(1'b0, '0, 1'b1);
        pulses = 0;
        for (int k = 1; k <= 3 * DEPTH; k++) begin
            drive(1'b1, IN_WIDTH'(k), 1'b0);
            if (out_valid) begin
                if (pulses < 3) sums[pulses] = out;
                pulses++;
            end
        end
        check("decim_pulses", 32'(pulses), 32'd3);
        check("decim_sum0", 32'(sums[0]), 32'd136);
        check("decim_sum1", 32'(sums[1]), 32'd392);
        check("decim_sum2", 32'(sums[2]), 32'd648);
`else
        pulses  = 0;
        sums[0] = '0;
        sums[1] = '0;
        sums[2] = '0;
`endif

        // Randomized traffic with gaps, occasional clears and one mid-stream reset.
        for (int c = 0; c < 1500; c++) begin
            bit v;
            bit cl;
            v  = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 199) == 0);
            if (c == 700) do_reset(2);
            drive(v, IN_WIDTH'($urandom_range(0, 4095)), cl);
        end
        for (int c = 0; c < 40; c++) drive(1'b1, IN_WIDTH'($urandom_range(3000, 4095)), 1'b0);
        idle(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
